fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that consumes `j_br` and `target` from the execute stage (branch decision plus computed target) and owns the architectural PC.
- Issues one-at-a-time requests to instruction memory and buffers returned instructions in a small FIFO feeding decode.
- On redirect, flushes buffered and in-flight instructions and restarts fetch at `target`.

Parameters:
- `XLEN`, 32, width of PC, address and instruction.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `FQ_DEPTH`, 2, fetch-queue entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `j_br`  in  1  redirect request from execute (jump or taken branch).
- `target`  in  XLEN  redirect address; bits [1:0] ignored (forced 0).
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  fetch address (= PC, word aligned).
- `imem_gnt`  in  1  request accepted this cycle (meaningful only when `imem_req`=1).
- `imem_rvalid`  in  1  response valid; at least 1 cycle after its grant.
- `imem_rdata`  in  XLEN  instruction word for the outstanding request.
- `id_valid`  out  1  queue head valid for decode.
- `id_instr`  out  XLEN  head instruction.
- `id_pc`  out  XLEN  PC of head instruction.
- `id_ready`  in  1  decode accepts head this cycle.

Behaviour:
- Reset (`rst_n`=0 at edge):
  - state=S_IDLE, pc=RESET_PC, queue count=0, pointers=0.
  - Outputs: `imem_req`=0, `id_valid`=0; `imem_addr`=RESET_PC; `id_instr`/`id_pc` don't-care (`id_valid`=0).
  - Reset mid-transaction abandons any outstanding request. Memory is reset together, so no late rvalid is expected.
- States:
  - S_IDLE → S_REQ unconditionally next cycle.
  - S_REQ: `imem_req` = (count < FQ_DEPTH), `imem_addr`=pc. On gnt: pc ← pc+4 (wraps modulo 2^XLEN), go S_WAIT.
  - S_WAIT: `imem_req`=0. On rvalid: push {pc_of_req, `imem_rdata`}, go S_REQ. Same-cycle re-request is not allowed.
  - S_DROP: `imem_req`=0. On rvalid: discard data, go S_REQ.
- At most one request outstanding. A request is issued only when count < FQ_DEPTH, so a push never overflows: at most one push per slot reserved, with count+outstanding ≤ FQ_DEPTH enforced by requesting only when count+(state==S_WAIT) < FQ_DEPTH.
- Request address may change while `imem_req`=1 and not granted (redirect case); memory samples the address only on gnt.
- Queue:
  - `id_valid` = (count≠0); head is registered storage, zero cycles from storage to outputs.
  - Pop when `id_valid` & `id_ready`.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo FQ_DEPTH.
  - A pushed entry is visible on `id_*` the cycle after rvalid (fetch latency = gnt cycle + ≥1 response cycle + 1).
- Redirect (`j_br`=1), priority over all other events that cycle:
  - pc ← {target[XLEN-1:2],2'b00}; count ← 0; pop and push suppressed.
  - S_REQ without gnt: stay S_REQ (next cycle `imem_addr`=new pc).
  - S_REQ with gnt: granted fetch is stale → S_DROP; pc still ← target (not target+4).
  - S_WAIT without rvalid → S_DROP.
  - S_WAIT with rvalid: discard data → S_REQ.
  - S_DROP with rvalid → S_REQ. S_DROP without rvalid → stay S_DROP.
  - S_IDLE → S_REQ.
  - Back-to-back redirects: the last one wins.
- `id_pc` of each instruction equals the address it was fetched from. The execute stage uses it for target computation.

Test Plan:
- Reset then zero-wait memory (gnt=1 always, rvalid 1 cycle after gnt), `id_ready`=1 → `imem_addr` sequence 0x0,0x4,0x8; `id_pc` 0x0,0x4,0x8 with matching `id_instr`; `imem_req`=0 during reset and the first cycle after.
- `id_ready`=0 for 10 cycles → count saturates at 2 (0x0,0x4 held), `imem_req`=0 while full; on `id_ready`=1 fetch resumes at 0x8, no loss or duplication.
- `j_br`=1, `target`=0x100 in S_WAIT with rvalid 3 cycles later → response dropped, queue emptied, next `imem_addr`=0x100, first `id_pc`=0x100.
- `j_br`=1, `target`=0x203 in the same cycle as gnt for 0x10 → 0x10 data discarded, next request `imem_addr`=0x200.
- `j_br` same cycle as pop and rvalid → `id_valid`=0 next cycle, count=0, nothing pushed; `j_br` pulsed on two consecutive cycles (0x40 then 0x80) → fetch resumes at 0x80.
- pc=0xFFFF_FFFC fetched → next `imem_addr`=0x0000_0000; `rst_n`=0 asserted in S_WAIT → `imem_req`=0, `id_valid`=0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and queues returned words for decode; redirects flush.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            j_br,
  input  logic [XLEN-1:0] target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, req_pc, redir_pc;
  fq_entry_t       fq [FQ_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            granted, push, pop;

  assign redir_pc  = target & ~XLEN'(3);
  assign imem_req  = (state == S_REQ) && (count < CW'(FQ_DEPTH));
  assign imem_addr = pc;
  assign granted   = imem_req & imem_gnt;

  // Redirect suppresses both queue ports; a response arriving with it is stale.
  assign push = (state == S_WAIT) & imem_rvalid & ~j_br;
  assign pop  = id_valid & id_ready & ~j_br;

  assign id_valid = (count != '0);
  assign id_instr = fq[rptr].instr;
  assign id_pc    = fq[rptr].pc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (granted) state_nxt = j_br ? S_DROP : S_WAIT;
      S_WAIT: if (imem_rvalid) state_nxt = S_REQ;
              else if (j_br) state_nxt = S_DROP;
      S_DROP: if (imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (j_br)         pc_nxt = redir_pc;
    else if (granted) pc_nxt = pc + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (granted) req_pc <= pc;
      if (j_br) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage carries no reset; id_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) fq[wptr] <= '{pc: req_pc, instr: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus, a
// scoreboard of expected {pc, instr} per grant, and a decoupled pop monitor.
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, j_br, imem_req, imem_gnt, imem_rvalid, id_valid, id_ready;
  logic [31:0] target, imem_addr, imem_rdata, id_instr, id_pc;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .j_br(j_br), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          errors = 0, checks = 0;
  exp_t        exp_q[$];
  logic [31:0] gexp, oaddr, last_gaddr;
  bit          outstanding;
  int          lat, n_gnt = 0, n_pop = 0;
  int          gnt_pct = 100, rdy_pct = 100, min_lat = 0, max_lat = 0;

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Pop monitor: every accepted instruction must be the oldest surviving fetch.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && j_br === 1'b0) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: id_pc %h delivered with nothing expected", id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.instr);
      end
    end
  end

  // One cycle of memory/decode/execute behaviour, called at a falling edge.
  task automatic drive(input bit jb, input logic [31:0] tgt, input bit f_rdy, input bit f_gnt);
    checks++;
    if (imem_req && outstanding) begin
      errors++;
      $display("FAIL one_outstanding: imem_req=1 while fetch of %h pending", oaddr);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (outstanding) begin
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(oaddr);
        outstanding = 1'b0;
      end else lat--;
    end
    imem_gnt = f_gnt || ($urandom_range(99) < gnt_pct);
    id_ready = f_rdy || ($urandom_range(99) < rdy_pct);
    j_br     = jb;
    target   = jb ? tgt : $urandom;
    if (imem_req && imem_gnt) begin
      chk("grant_addr", imem_addr, gexp);
      exp_q.push_back('{pc: gexp, instr: memf(gexp)});
      oaddr       = imem_addr;
      outstanding = 1'b1;
      lat         = $urandom_range(max_lat, min_lat);
      last_gaddr  = imem_addr;
      n_gnt++;
      gexp = gexp + 32'd4;
    end
    if (jb) begin
      exp_q.delete();
      gexp = {tgt[31:2], 2'b00};
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_gnt(input string name);
    int g0;
    g0 = n_gnt;
    for (int i = 0; i < 200 && n_gnt == g0; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    if (n_gnt == g0) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 200 cycles", name);
    end
  endtask

  // Called at a falling edge; memory is reset along with the DUT.
  task automatic do_reset();
    rst_n = 1'b0; j_br = 1'b0; target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    outstanding = 1'b0; lat = 0; exp_q.delete(); gexp = RESET_PC;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("idle_no_req", imem_req, 0);
  endtask

  initial begin
    bit hit;
    int p0;
    rst_n = 1'b0; j_br = 1'b0; target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-wait memory, decode always ready.
    @(negedge clk);
    chk("req_first", imem_req, 1);
    chk("addr_first", imem_addr, RESET_PC);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("valid_before_resp", id_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("valid_latency", id_valid, 1);
    chk("pc_first", id_pc, RESET_PC);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    run(20);

    // Decode stalled: queue fills to depth and requests stop.
    @(negedge clk);
    do_reset();
    rdy_pct = 0;
    run(12);
    @(negedge clk);
    chk("full_no_req", imem_req, 0);
    chk("full_valid", id_valid, 1);
    chk("full_head_pc", id_pc, RESET_PC);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rdy_pct = 100;
    wait_gnt("resume");
    chk("resume_addr", last_gaddr, 32'h8);
    run(10);

    // Redirect while waiting; response arrives three cycles after grant.
    min_lat = 2; max_lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (outstanding && lat > 0) begin
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        hit = 1'b1;
      end else drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("wait_redirect_found", hit, 1);
    @(negedge clk);
    chk("wait_redirect_flush", id_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    wait_gnt("after_wait_redirect");
    chk("wait_redirect_addr", last_gaddr, 32'h100);
    run(10);

    // Redirect in the same cycle as the grant of 0x10.
    min_lat = 0; max_lat = 0;
    @(negedge clk);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h10) begin
        drive(1'b1, 32'h203, 1'b0, 1'b1);
        hit = 1'b1;
      end else drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("gnt_redirect_found", hit, 1);
    wait_gnt("after_gnt_redirect");
    chk("gnt_redirect_addr", last_gaddr, 32'h200);
    run(10);

    // Redirect coinciding with a pop and a response, then a second redirect.
    rdy_pct = 40; max_lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (id_valid && outstanding && lat == 0) begin
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        hit = 1'b1;
      end else drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("pop_redirect_found", hit, 1);
    @(negedge clk);
    chk("pop_redirect_flush", id_valid, 0);
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    rdy_pct = 100; max_lat = 0;
    wait_gnt("after_double_redirect");
    chk("double_redirect_addr", last_gaddr, 32'h80);
    run(10);

    // Address wrap at the top of memory.
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    wait_gnt("wrap_top");
    chk("wrap_top_addr", last_gaddr, 32'hFFFF_FFFC);
    wait_gnt("wrap_zero");
    chk("wrap_zero_addr", last_gaddr, 32'h0);
    run(10);

    // Reset while a fetch is outstanding.
    min_lat = 3; max_lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (outstanding && lat > 0) hit = 1'b1;
      else drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("rst_wait_found", hit, 1);
    do_reset();
    min_lat = 0; max_lat = 0;
    wait_gnt("after_rst");
    chk("rst_restart_addr", last_gaddr, RESET_PC);
    run(10);

    // Randomized traffic.
    gnt_pct = 70; rdy_pct = 60; min_lat = 0; max_lat = 4;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : ($urandom & 32'h0000_FFFF);
      @(negedge clk);
      drive($urandom_range(99) < 3, tgt, 1'b0, 1'b0);
    end
    chk("random_progress", (n_pop - p0) > 300, 1);
    rdy_pct = 100; gnt_pct = 100;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
